// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Purpose  : Registered program counter with branch, LUT jump, stall and halt.
//            Optional call/return stack enabled by defining PC_CALL_RET_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int PC_W      = 32,
    parameter int OFF_W     = 7,
    parameter int OFF_SHIFT = 2,
    parameter int PC_STEP   = 1,
    parameter int RESET_PC  = 0,
    parameter int LUT_DEPTH = 16,
    parameter int RAS_DEPTH = 4,
    localparam int IDX_W    = $clog2(LUT_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic [1:0]       br_mode,
    input  logic             zero,
    input  logic [OFF_W-1:0] offset,
    input  logic             jump,
    input  logic [IDX_W-1:0] jump_idx,
    input  logic             lut_we,
    input  logic [IDX_W-1:0] lut_waddr,
    input  logic [PC_W-1:0]  lut_wdata,
    input  logic             call,
    input  logic             ret,
    output logic [PC_W-1:0]  pc,
    output logic             taken,
    output logic             done,
    output logic             ras_err
);

    localparam logic [0:0] S_RUN    = 1'b0;
    localparam logic [0:0] S_HALTED = 1'b1;

    localparam logic [PC_W-1:0] c_step     = PC_W'(PC_STEP);
    localparam logic [PC_W-1:0] c_reset_pc = PC_W'(RESET_PC);

    logic [0:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            taken_q, taken_d;
    logic            done_q, done_d;
    logic [PC_W-1:0] lut_q [LUT_DEPTH];

    logic [PC_W-1:0] w_seq;
    logic [PC_W-1:0] w_off_ext;
    logic [PC_W-1:0] w_br_tgt;
    logic            w_br_take;
    logic [PC_W-1:0] w_lut_rd;

    assign w_seq     = pc_q + c_step;
    assign w_off_ext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
    assign w_br_tgt  = w_seq + (w_off_ext << OFF_SHIFT);
    assign w_lut_rd  = lut_q[jump_idx];

    always_comb begin
        w_br_take = 1'b0;
        case (br_mode)
            2'b01:   w_br_take = zero;
            2'b10:   w_br_take = ~zero;
            2'b11:   w_br_take = 1'b1;
            default: w_br_take = 1'b0;
        endcase
    end

`ifdef PC_CALL_RET_EN
    localparam int SP_W = $clog2(RAS_DEPTH + 1);
    localparam int RI_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0] ras_q [RAS_DEPTH];
    logic [SP_W-1:0] sp_q, sp_d;
    logic            ras_err_q, ras_err_d;
    logic            w_push, w_pop;
    logic [SP_W-1:0] w_top;
    logic            w_full, w_empty;

    assign w_top   = sp_q - SP_W'(1);
    assign w_full  = (sp_q == SP_W'(RAS_DEPTH));
    assign w_empty = (sp_q == '0);
    assign ras_err = ras_err_q;
`else
    logic w_unused_ret;
    assign w_unused_ret = ret | (RAS_DEPTH == 0);
    assign ras_err      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_RUN;
        else       state_q <= state_d;
    end

    // Next-state logic: HALTED is left only through reset
    always_comb begin
        state_d = state_q;
        if (state_q == S_RUN && halt) state_d = S_HALTED;
    end

    // Output / datapath next-value logic
    always_comb begin
        pc_d    = pc_q;
        taken_d = 1'b0;
        done_d  = (state_d == S_HALTED);
`ifdef PC_CALL_RET_EN
        ras_err_d = ras_err_q;
        w_push    = 1'b0;
        w_pop     = 1'b0;
`endif
        if (state_q == S_RUN && !halt && !stall) begin
`ifdef PC_CALL_RET_EN
            if (ret) begin
                if (w_empty) begin
                    pc_d      = w_seq;
                    ras_err_d = 1'b1;
                end else begin
                    pc_d    = ras_q[w_top[RI_W-1:0]];
                    taken_d = 1'b1;
                    w_pop   = 1'b1;
                end
            end else if (call) begin
                // Redirect happens even when the stack cannot take the return address
                pc_d    = w_lut_rd;
                taken_d = 1'b1;
                if (w_full) ras_err_d = 1'b1;
                else        w_push    = 1'b1;
            end else
`endif
            if (call || jump) begin
                pc_d    = w_lut_rd;
                taken_d = 1'b1;
            end else if (w_br_take) begin
                pc_d    = w_br_tgt;
                taken_d = 1'b1;
            end else begin
                pc_d = w_seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= c_reset_pc;
            taken_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            done_q  <= done_d;
        end
    end

    // Jump-target LUT: reads see the pre-write contents in the write cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
        end else if (lut_we) begin
            lut_q[lut_waddr] <= lut_wdata;
        end
    end

`ifdef PC_CALL_RET_EN
    always_comb begin
        sp_d = sp_q;
        if (w_push)     sp_d = sp_q + SP_W'(1);
        else if (w_pop) sp_d = sp_q - SP_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q      <= '0;
            ras_err_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            sp_q      <= sp_d;
            ras_err_q <= ras_err_d;
            if (w_push) ras_q[sp_q[RI_W-1:0]] <= w_seq;
        end
    end
`endif

    assign pc    = pc_q;
    assign taken = taken_q;
    assign done  = done_q;

endmodule
`default_nettype wire
